// File: rtl/coproc_mem_reader.sv
// Coprocessor memory read engine: one 32-bit read per start/done handshake,
// split into two word-aligned OBI beats when the byte address is unaligned.
module coproc_mem_reader #(
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cp_start_i,
  input  logic [31:0] cp_addr_i,
  output logic [31:0] cp_rdata_o,
  output logic        cp_done_o,
  output logic        cp_busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [29:0] word_next;
  logic [31:0] merged;

  // The second beat wraps within the 30-bit word address space.
  assign word_next = word_q + 30'd1;

  // Little-endian merge: drop the low off_q bytes of the first word and
  // fill the top with the lowest bytes of the second word.
  always_comb begin
    merged = lo_q;
    case (off_q)
      2'd1:    merged = {mem_rdata_i[7:0],  lo_q[31:8]};
      2'd2:    merged = {mem_rdata_i[15:0], lo_q[31:16]};
      2'd3:    merged = {mem_rdata_i[23:0], lo_q[31:24]};
      default: merged = lo_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    off_d   = off_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cp_start_i) begin
          word_d  = cp_addr_i[31:2];
          off_d   = ALLOW_UNALIGNED ? cp_addr_i[1:0] : 2'b00;
          state_d = REQ0;
        end
      end
      REQ0: begin
        if (mem_gnt_i) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid_i) begin
          lo_d = mem_rdata_i;
          if (off_q == 2'b00) begin
            rdata_d = mem_rdata_i;
            state_d = DONE;
          end else begin
            state_d = REQ1;
          end
        end
      end
      REQ1: begin
        if (mem_gnt_i) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid_i) begin
          rdata_d = merged;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      off_q   <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // All handshake outputs decode from registered state only.
  assign mem_req_o  = (state_q == REQ0) || (state_q == REQ1);
  assign mem_addr_o = (state_q == REQ0) ? {word_q, 2'b00} :
                      (state_q == REQ1) ? {word_next, 2'b00} : 32'h0;
  assign cp_busy_o  = (state_q != IDLE);
  assign cp_done_o  = (state_q == DONE);
  assign cp_rdata_o = rdata_q;

endmodule

// File: doc/coproc_mem_reader.md
# coproc_mem_reader

Memory read engine feeding the custom-instruction coprocessors (e.g. the bit-interleaving unit). Accepts a single 32-bit read request via a start/done handshake with an arbitrary byte address. Issues one or two word-aligned transactions on an OBI-style data port, merges unaligned data little-endian, and returns one 32-bit word. Sits between the coprocessor read interface and the core data-memory arbiter.

## Interface
- ALLOW_UNALIGNED, 1: 1 = byte-offset reads split into two word beats; 0 = addr[1:0] ignored, always one aligned beat.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cp_start_i  in  1  coprocessor read request pulse; sampled only in IDLE.
- cp_addr_i  in  32  byte address; sampled with cp_start_i.
- cp_rdata_o  out  32  returned word; registered, held until next completion.
- cp_done_o  out  1  one-cycle pulse: cp_rdata_o valid.
- cp_busy_o  out  1  high in every state except IDLE.
- mem_req_o  out  1  OBI request.
- mem_addr_o  out  32  word-aligned address (bits[1:0] = 0).
- mem_gnt_i  in  1  OBI grant.
- mem_rvalid_i  in  1  OBI response valid.
- mem_rdata_i  in  32  OBI response data.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: on cp_start_i, register addr_q <= cp_addr_i, off_q <= cp_addr_i[1:0] (forced 0 if ALLOW_UNALIGNED=0); go REQ0.
- REQ0: mem_req_o=1, mem_addr_o={addr_q[31:2],2'b00}; on mem_gnt_i go WAIT0.
- WAIT0: on mem_rvalid_i capture lo_q <= mem_rdata_i; if off_q==0 go DONE, else go REQ1.
- REQ1: mem_req_o=1, mem_addr_o={addr_q[31:2]+1,2'b00} (30-bit wrap: 0xFFFFFFFC -> 0x00000000); on mem_gnt_i go WAIT1.
- WAIT1: on mem_rvalid_i go DONE with cp_rdata_o <= ({mem_rdata_i, lo_q} >> (8*off_q))[31:0].
- Aligned path: cp_rdata_o <= lo_q on entering DONE (equivalently loaded from mem_rdata_i in WAIT0).
- DONE: cp_done_o=1 for exactly one cycle; go IDLE.
- cp_start_i outside IDLE is ignored (no queueing). cp_start_i in DONE is also ignored.
- mem_req_o and mem_addr_o stable from assertion until the grant cycle; mem_req_o low in all non-REQ states.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored (no state or data change).
- Exactly one outstanding transaction; a new request is issued only after the previous rvalid.

## Timing
- Reset values: cp_rdata_o=0, cp_done_o=0, cp_busy_o=0, mem_req_o=0, mem_addr_o=0, state=IDLE.
- mem_req_o/mem_addr_o/cp_busy_o/cp_done_o are decoded from registered state only (no combinational path from any input).
- Aligned, zero-wait memory: start cycle 0, req+gnt cycle 1, rvalid cycle 2, done cycle 3 (latency 3).
- Unaligned, zero-wait: req1+gnt cycle 3, rvalid cycle 4, done cycle 5 (latency 5).
- Each grant-wait cycle adds 1; each rvalid-wait cycle adds 1.
- Back-to-back: next cp_start_i accepted at earliest in the cycle after done (IDLE).
- Reset mid-operation: immediate return to IDLE, mem_req_o low asynchronously; a late rvalid after reset release is ignored.

## Test plan
- Reset: assert rst_ni=0 mid-REQ0 -> mem_req_o=0 immediately, cp_busy_o=0, cp_rdata_o=0; post-release stray rvalid causes no done.
- Aligned read, zero wait: addr 0x0000_1000, mem word 0xDEADBEEF -> single req at 0x1000, cp_done_o cycle 3, cp_rdata_o=0xDEADBEEF.
- Unaligned read: addr 0x0000_2002, words @0x2000=0x44332211, @0x2004=0x88776655 -> two reqs (0x2000, 0x2004), cp_rdata_o=0x66554433, done cycle 5.
- Wrap-around: addr 0xFFFF_FFFD, @0xFFFFFFFC=0xAABBCCDD, @0x0=0x11223344 -> second req address 0x00000000, cp_rdata_o=0x44AABBCC.
- Backpressure: gnt delayed 3 cycles, rvalid delayed 2 -> mem_addr_o stable during req, done at cycle 8 (aligned); cp_start_i pulsed while busy ignored (exactly one done).
- ALLOW_UNALIGNED=0: addr 0x0000_3003, @0x3000=0x12345678 -> one req at 0x3000, cp_rdata_o=0x12345678.
